// File: rtl/obstacle_datapath.sv
// obstacle_datapath: player/obstacle state, hit test and the VGA
// pixel stream driven by the game controller's draw/writeEnable.
module obstacle_datapath #(
  parameter int FRAME_TICKS = 833333,
  parameter int START_X     = 0,
  parameter int START_Y     = 56,
  parameter int END_X       = 156,
  parameter int OB0_X       = 60,
  parameter int OB0_Y       = 40,
  parameter int OB1_X       = 110,
  parameter int OB1_Y       = 70
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       draw,
  input  logic       writeEnable,
  input  logic       move_up,
  input  logic       move_down,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       finish
);

  typedef enum logic [2:0] {
    S_INIT,
    S_DRAW,
    S_WAIT,
    S_CHECK,
    S_ERASE,
    S_DONE
  } state_t;

  localparam logic [7:0]  SX    = 8'(START_X);
  localparam logic [6:0]  SY    = 7'(START_Y);
  localparam logic [7:0]  ENDX  = 8'(END_X);
  localparam logic [7:0]  OB0X  = 8'(OB0_X);
  localparam logic [6:0]  OB0Y  = 7'(OB0_Y);
  localparam logic [7:0]  OB1X  = 8'(OB1_X);
  localparam logic [6:0]  OB1Y  = 7'(OB1_Y);
  localparam logic [31:0] TLAST = 32'(FRAME_TICKS - 1);

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [31:0] tick_q, tick_d;
  logic [7:0]  px_q, px_d, pnx_q, pnx_d;
  logic [6:0]  py_q, py_d, pny_q, pny_d;
  logic        fin_q, fin_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [2:0]  col_q, col_d;
  logic        plot_q, plot_d;

  logic [7:0]  nx;
  logic [6:0]  ny;
  logic        blocked;
  logic        pix_on;
  logic [7:0]  pix_x;
  logic [6:0]  pix_y;
  logic [2:0]  pix_c;

  function automatic logic hit(
    input logic [7:0] ox,
    input logic [6:0] oy,
    input logic [7:0] hx,
    input logic [6:0] hy
  );
    logic [7:0] ey;
    logic [7:0] eo;
    ey = {1'b0, hy};
    eo = {1'b0, oy};
    return (hx + 8'd3 >= ox) && (hx <= ox + 8'd3) &&
           (ey + 8'd3 >= eo) && (ey <= eo + 8'd15);
  endfunction

  always_comb begin
    nx = px_q + 8'd1;
    ny = py_q;
    if (move_up && !move_down && py_q != 7'd0)
      ny = py_q - 7'd1;
    else if (move_down && !move_up && py_q < 7'd116)
      ny = py_q + 7'd1;
    blocked = hit(OB0X, OB0Y, nx, ny) ||
              hit(OB1X, OB1Y, nx, ny) ||
              (nx == ENDX);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = tick_q;
    px_d    = px_q;
    py_d    = py_q;
    pnx_d   = pnx_q;
    pny_d   = pny_q;
    fin_d   = fin_q;
    pix_on  = 1'b0;
    pix_x   = px_q + {6'd0, cnt_q[1:0]};
    pix_y   = py_q + {5'd0, cnt_q[3:2]};
    pix_c   = 3'b000;
    // draw=0 freezes everything, so the phase resumes where it stopped
    if (draw) begin
      unique case (state_q)
        S_INIT: begin
          pix_on = 1'b1;
          pix_c  = 3'b100;
          pix_x  = (cnt_q[6] ? OB1X : OB0X) + {6'd0, cnt_q[1:0]};
          pix_y  = (cnt_q[6] ? OB1Y : OB0Y) + {3'd0, cnt_q[5:2]};
          cnt_d  = cnt_q + 7'd1;
          if (cnt_q == 7'd127)
            state_d = S_DRAW;
        end
        S_DRAW: begin
          pix_on = 1'b1;
          pix_c  = 3'b111;
          cnt_d  = cnt_q + 7'd1;
          if (cnt_q == 7'd15) begin
            cnt_d   = 7'd0;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          tick_d = tick_q + 32'd1;
          if (tick_q == TLAST) begin
            tick_d  = 32'd0;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (blocked) begin
            fin_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            pnx_d   = nx;
            pny_d   = ny;
            state_d = S_ERASE;
          end
        end
        S_ERASE: begin
          pix_on = 1'b1;
          cnt_d  = cnt_q + 7'd1;
          if (cnt_q == 7'd15) begin
            cnt_d   = 7'd0;
            px_d    = pnx_q;
            py_d    = pny_q;
            state_d = S_DRAW;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_INIT;
        end
      endcase
    end
    x_d    = pix_on ? pix_x : x_q;
    y_d    = pix_on ? pix_y : y_q;
    col_d  = pix_on ? pix_c : col_q;
    plot_d = pix_on & writeEnable;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= S_INIT;
      cnt_q   <= 7'd0;
      tick_q  <= 32'd0;
      px_q    <= SX;
      py_q    <= SY;
      pnx_q   <= SX;
      pny_q   <= SY;
      fin_q   <= 1'b0;
      x_q     <= 8'd0;
      y_q     <= 7'd0;
      col_q   <= 3'd0;
      plot_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      px_q    <= px_d;
      py_q    <= py_d;
      pnx_q   <= pnx_d;
      pny_q   <= pny_d;
      fin_q   <= fin_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      plot_q  <= plot_d;
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = col_q;
  assign plot   = plot_q;
  assign finish = fin_q;

endmodule
